// File: rtl/sqrl_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// sqrl_uart_tx_fifo : FIFO-buffered UART transmitter, configurable frame format
// Optional CTS flow control: define SQRL_UART_TX_CTS_EN
// Revision: 1.0
// ============================================================================
module sqrl_uart_tx_fifo #(
  parameter int comm_clk_frequency = 100000000,
  parameter int baud_rate          = 115200,
  parameter int data_bits          = 8,
  parameter int parity             = 0,
  parameter int stop_bits          = 1,
  parameter int fifo_depth         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          uart_tx,
  input  logic                          tx_new_byte,
  input  logic [data_bits-1:0]          tx_byte,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(fifo_depth):0]   fifo_count
`ifdef SQRL_UART_TX_CTS_EN
  ,
  input  logic                          cts_n
`endif
);

  localparam int unsigned c_aw         = $clog2(fifo_depth);
  localparam int unsigned c_cw         = c_aw + 1;
  localparam logic [15:0] c_baud_delay = 16'(comm_clk_frequency / baud_rate - 1);
  localparam logic [3:0]  c_last_data  = 4'(data_bits - 1);
  localparam logic [3:0]  c_last_stop  = 4'(stop_bits - 1);
  localparam logic        c_odd        = (parity == 1);
  localparam logic        c_has_par    = (parity != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic [15:0]           r_timer;
  logic [3:0]            r_bit_cnt;
  logic [data_bits-1:0]  r_shift;
  logic                  r_par;
  logic [data_bits-1:0]  r_mem [fifo_depth];
  logic [c_aw-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_cw-1:0]       r_count;
  logic                  w_wr, w_pop, w_bit_end, w_cts_ok, w_can_send, w_line;
  logic [data_bits-1:0]  w_head;

`ifdef SQRL_UART_TX_CTS_EN
  logic [1:0] r_cts_sync;
  // Reset to "not clear" so nothing leaves before the line state is known.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cts_sync <= 2'b11;
    else       r_cts_sync <= {r_cts_sync[0], cts_n};
  end
  assign w_cts_ok = ~r_cts_sync[1];
`else
  assign w_cts_ok = 1'b1;
`endif

  assign w_wr       = tx_new_byte && tx_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_can_send = (r_count != '0) && w_cts_ok;
  assign w_bit_end  = (r_timer == c_baud_delay);
  assign tx_ready   = (r_count != c_cw'(fifo_depth));
  assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= tx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_send) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && r_bit_cnt == c_last_data)
          w_state_next = c_has_par ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
      S_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (w_bit_end && r_bit_cnt == c_last_stop) begin
          if (w_can_send) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else begin
      r_timer <= (r_state == S_IDLE || w_bit_end) ? 16'd0 : r_timer + 16'd1;
      if (w_state_next != r_state)
        r_bit_cnt <= '0;
      else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP))
        r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ c_odd;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
      S_PARITY: w_line = r_par;
      default:  w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) uart_tx <= 1'b1;
    else       uart_tx <= w_line;
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrl_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_sqrl_uart_tx_fifo : directed self-checking bench for sqrl_uart_tx_fifo
// Revision: 1.0
// ============================================================================
module tb_sqrl_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_a, new_a, tx_a, rdy_a, busy_a;
  logic [7:0] byte_a;
  logic [4:0] cnt_a;
  logic       rst_b, new_b, tx_b, rdy_b, busy_b;
  logic [6:0] byte_b;
  logic [2:0] cnt_b;
`ifdef SQRL_UART_TX_CTS_EN
  logic       cts_a, cts_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic saw_low;

  always #5 clk = ~clk;

  // 8N1, bit period 4, depth 16
  sqrl_uart_tx_fifo #(.comm_clk_frequency(4), .baud_rate(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .uart_tx(tx_a), .tx_new_byte(new_a), .tx_byte(byte_a),
    .tx_ready(rdy_a), .tx_busy(busy_a), .fifo_count(cnt_a)
`ifdef SQRL_UART_TX_CTS_EN
    , .cts_n(cts_a)
`endif
  );

  // 7O2, bit period 4, depth 4
  sqrl_uart_tx_fifo #(.comm_clk_frequency(4), .baud_rate(1), .data_bits(7), .parity(1),
                      .stop_bits(2), .fifo_depth(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .uart_tx(tx_b), .tx_new_byte(new_b), .tx_byte(byte_b),
    .tx_ready(rdy_b), .tx_busy(busy_b), .fifo_count(cnt_b)
`ifdef SQRL_UART_TX_CTS_EN
    , .cts_n(cts_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic write_a(input logic [7:0] d);
    new_a = 1'b1; byte_a = d;
    @(posedge clk); #1;
    new_a = 1'b0;
  endtask

  task automatic write_b(input logic [6:0] d);
    new_b = 1'b1; byte_b = d;
    @(posedge clk); #1;
    new_b = 1'b0;
  endtask

  // bits: line values in send order, LSB first; each held 4 cycles
  task automatic check_frame(input int s, input logic [15:0] bits, input int n, input string tag);
    logic [15:0] sh;
    for (int i = 0; i < n * 4; i++) begin
      @(posedge clk); #1;
      sh = bits >> (i / 4);
      check(tag, 32'(s != 0 ? tx_b : tx_a), 32'(sh[0]));
    end
  endtask

  task automatic watch_idle(input int s, input int cycles);
    saw_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if ((s != 0 ? tx_b : tx_a) == 1'b0) saw_low = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt [6] = '{1, 2, 3, 4, 4, 4};
    int exp_rdy [6] = '{1, 1, 1, 0, 0, 0};
    logic [3:0] pars = 4'b0100;
    rst_a = 1'b1; rst_b = 1'b1;
    new_a = 1'b0; new_b = 1'b0; byte_a = '0; byte_b = '0;
`ifdef SQRL_UART_TX_CTS_EN
    cts_a = 1'b0; cts_b = 1'b0;
`endif
    repeat (3) @(posedge clk); #1;
    check("rst_tx_a",  32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_rdy_a", 32'(rdy_a), 32'd1);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_tx_b",  32'(tx_b), 32'd1);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk); #1;

    // 0xA5 on 8N1: start at k+2, 40 cycles
    write_a(8'hA5);
    check("a5_cnt1", 32'(cnt_a), 32'd1);
    check("a5_busy", 32'(busy_a), 32'd1);
    check("a5_tx_k", 32'(tx_a), 32'd1);
    @(posedge clk); #1;
    check("a5_tx_k1", 32'(tx_a), 32'd1);
    check("a5_cnt0", 32'(cnt_a), 32'd0);
    check_frame(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, "a5_line");
    check("a5_idle", 32'(busy_a), 32'd0);

    // 0x41 on 7O2: parity bit 1, 11 bit periods
    write_b(7'h41);
    @(posedge clk); #1;
    check("41_tx_k1", 32'(tx_b), 32'd1);
    check_frame(1, {5'd0, 2'b11, 1'b1, 7'h41, 1'b0}, 11, "41_line");
    check("41_idle", 32'(busy_b), 32'd0);

    // Depth 4: 0x11 pops at once, then 6 writes; 4 accepted, 2 dropped
    write_b(7'h11);
    for (int i = 0; i < 6; i++) begin
      write_b(7'(i + 1));
      check("full_cnt", 32'(cnt_b), 32'(exp_cnt[i]));
      check("full_rdy", 32'(rdy_b), 32'(exp_rdy[i]));
    end
    repeat (39) @(posedge clk); #1;
    check("full_cnt3", 32'(cnt_b), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check_frame(1, {5'd0, 2'b11, pars[i], 7'(i + 1), 1'b0}, 11, "b2b_line");
      check("b2b_cnt", 32'(cnt_b), 32'(i < 3 ? 2 - i : 0));
    end
    check("b2b_idle", 32'(busy_b), 32'd0);
    watch_idle(1, 20);
    check("b2b_nodrop", 32'(saw_low), 32'd0);

    // Reset in DATA of the second frame
    write_a(8'h12);
    write_a(8'h34);
    write_a(8'h56);
    repeat (48) @(posedge clk); #1;
    check("mid_cnt", 32'(cnt_a), 32'd1);
    rst_a = 1'b1; #1;
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_rdy", 32'(rdy_a), 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b0;
    watch_idle(0, 100);
    check("post_rst_quiet", 32'(saw_low), 32'd0);
    write_a(8'h3C);
    @(posedge clk); #1;
    check_frame(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, "3c_line");
    check("3c_idle", 32'(busy_a), 32'd0);

`ifdef SQRL_UART_TX_CTS_EN
    cts_a = 1'b1;
    repeat (3) @(posedge clk); #1;
    write_a(8'hC3);
    write_a(8'h5A);
    watch_idle(0, 20);
    check("cts_hold", 32'(saw_low), 32'd0);
    check("cts_cnt2", 32'(cnt_a), 32'd2);
    cts_a = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("cts_sync", 32'(tx_a), 32'd1);
    end
    check("cts_cnt1", 32'(cnt_a), 32'd1);
    fork
      begin
        repeat (10) @(posedge clk);
        #2 cts_a = 1'b1;
      end
    join_none
    check_frame(0, {6'd0, 1'b1, 8'hC3, 1'b0}, 10, "cts_line");
    watch_idle(0, 30);
    check("cts_withheld", 32'(saw_low), 32'd0);
    check("cts_kept", 32'(cnt_a), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sqrl_uart_tx_fifo.md
# sqrl_uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format (data bits, parity, stop bits) and optional CTS flow control. Sits on the comm clock domain between the host-side reporting logic and the board UART pin. Accepts bytes at full clock rate into a FIFO and serialises them back-to-back with no inter-frame gap. Next-generation replacement for the single-byte, fixed 8N1 transmitter.

## Interface
Parameters:
- comm_clk_frequency, 100000000, clock frequency in Hz
- baud_rate, 115200, line rate; baud_delay = comm_clk_frequency/baud_rate - 1 (16-bit), bit period = baud_delay+1 cycles
- data_bits, 8, data bits per frame, legal 5..9
- parity, 0, 0 = none, 1 = odd, 2 = even
- stop_bits, 1, legal 1 or 2
- fifo_depth, 16, FIFO entries, power of two, >= 2

Ports:
- clk  in  1  comm clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- uart_tx  out  1  serial line, idle high, registered
- tx_new_byte  in  1  write strobe, accepted when tx_ready high
- tx_byte  in  data_bits  data to send, LSB transmitted first
- tx_ready  out  1  FIFO not full (combinational from FIFO count)
- tx_busy  out  1  high while a frame is on the line or FIFO non-empty
- fifo_count  out  $clog2(fifo_depth)+1  entries held
- cts_n  in  1  clear-to-send, active-low (only with SQRL_UART_TX_CTS_EN)

## Operation
- FIFO: write on tx_new_byte && tx_ready; writes while full are dropped, no other effect. Pointers wrap modulo fifo_depth; count distinguishes full/empty.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if parity=0) -> STOP -> IDLE or START.
- IDLE: uart_tx=1. If FIFO non-empty (and CTS permits), pop head into shift register, go START.
- START: uart_tx=0 for one bit period.
- DATA: data_bits periods, LSB first; bit counter 0..data_bits-1.
- PARITY: one period; even = XOR of data bits, odd = its inverse.
- STOP: stop_bits periods of uart_tx=1. At end: if FIFO non-empty (and CTS permits) pop and go directly to START, else IDLE.
- Bit timer: 16-bit counter reset to 0 on every state/bit entry; bit ends when counter == baud_delay.
- Simultaneous write and pop in one cycle: both take effect, count unchanged; write into empty FIFO while IDLE is not popped the same cycle.
- Reset (any time, including mid-frame): uart_tx=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM IDLE, timer 0, FIFO contents discarded.

## Timing
- Write accepted at edge k into empty FIFO with FSM idle: pop at edge k+1, uart_tx falls at edge k+2.
- Frame length = (1 + data_bits + (parity?1:0) + stop_bits) x (baud_delay+1) cycles exactly.
- Back-to-back frames: start bit of frame n+1 begins the cycle after the last stop-bit cycle of frame n.
- tx_ready drops the cycle after the write that fills the FIFO; rises the cycle after the pop from full.
- fifo_count updates one cycle after the causing write/pop edge.

## Configuration
- SQRL_UART_TX_CTS_EN defined: cts_n port present, two-flop synchronised; FSM leaves IDLE or STOP-to-START only when synchronised cts_n = 0; a frame in progress always completes. cts_n high holds uart_tx idle-high with FIFO retained.
- Undefined: cts_n port absent; transmission governed only by FIFO occupancy.

## Test plan
- Defaults, baud_delay forced to 3 (bit period 4): write 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, start at k+2, tx_busy low after 40 cycles.
- data_bits=7, parity=1, stop_bits=2, write 0x41 -> start, 1000001, parity 1, two stop bits; 11 bit periods.
- fifo_depth=4: write 6 bytes consecutively -> first 4 accepted (tx_ready low after 4th), 5th/6th dropped; 4 frames emitted with zero gap, fifo_count 4->0.
- Assert reset mid-DATA of second frame -> uart_tx=1 immediately, fifo_count=0, no further frames; post-reset write 0x3C transmits cleanly.
- CTS_EN, cts_n=1, write 2 bytes -> uart_tx stays high, fifo_count=2; drop cts_n -> frame starts 3 cycles later; raise cts_n mid-frame -> that frame completes, second withheld.
